pending_encoder: RTL and testbench

- 8-to-3 encoder; the inverse of the team's 3-to-8 decoder.
- Latches 8 request lines into a sticky pending set and presents one pending index at a time as a 3-bit code.
- Index is offered on a valid/ready handshake; the served bit is cleared on acceptance.
- Sits in front of the decoder or a dispatcher: interrupt/event funnel, one event per transfer.

---
 rtl/pending_encoder.sv | 123 ++++++++++++
 tb/tb_pending_encoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pending_encoder.sv
// Sticky 8-line pending set encoded to one 3-bit index per valid/ready transfer.
// Optional macro PENDING_ENCODER_ROUND_ROBIN_EN selects round-robin instead of lowest-index priority.
module pending_encoder #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] enable,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         any_pending,
  output logic         ovf,
  input  logic         clr_ovf,
  output logic         dbg_state
);

  // Handshake: a transfer happens on every rising edge where out_valid and
  // out_ready are both high; out_idx is held stable while out_valid waits.
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t       state;
  logic [N-1:0] pending;
  logic         hs;
  logic [N-1:0] clr;
  logic [N-1:0] cand;
  logic         sel_found;
  logic [W-1:0] sel_idx;

  assign hs = out_valid & out_ready;

  always_comb begin
    clr = '0;
    if (hs) clr[out_idx] = 1'b1;
  end

  // The bit being accepted this cycle is never reselected, even if req re-arms it.
  assign cand = pending & enable & ~clr;

`ifdef PENDING_ENCODER_ROUND_ROBIN_EN
  logic [W-1:0] last;
  logic [W-1:0] base;
  logic [W-1:0] probe;

  // Search begins just past the most recent grant, counting this cycle's one.
  assign base = hs ? out_idx : last;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    probe     = '0;
    for (int i = 0; i < N; i++) begin
      probe = W'((int'(base) + 1 + i) % N);
      if (!sel_found && cand[probe]) begin
        sel_found = 1'b1;
        sel_idx   = probe;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) last <= W'(N - 1);
    else if (hs) last <= out_idx;
  end
`else
  always_comb begin
    sel_found = |cand;
    sel_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) sel_idx = W'(i);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      ovf       <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | req;
      if (|(req & pending & ~clr)) ovf <= 1'b1;
      else if (clr_ovf)            ovf <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            out_idx   <= sel_idx;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (hs) begin
            if (sel_found) begin
              out_idx <= sel_idx;
            end else begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    out_onehot = '0;
    if (out_valid) out_onehot[out_idx] = 1'b1;
  end

  assign any_pending = |pending;
  assign dbg_state   = (state == HOLD);

endmodule

// File: tb/tb_pending_encoder.sv
// Bench for pending_encoder: set-based reference model plus an accepted-index scoreboard.
// Honours PENDING_ENCODER_ROUND_ROBIN_EN the same way the design does.
module tb_pending_encoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] enable;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic [7:0] out_onehot;
  logic       any_pending;
  logic       ovf;
  logic       clr_ovf;
  logic       dbg_state;

  pending_encoder #(.N(8), .W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .enable     (enable),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_onehot (out_onehot),
    .any_pending(any_pending),
    .ovf        (ovf),
    .clr_ovf    (clr_ovf),
    .dbg_state  (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_q[$];

  // Reference model: pending lines as a set, the presented line as an int (-1 = none).
  bit m_pend[8];
  int m_cur;
  int m_last;
  bit m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] decode(input logic [2:0] idx);
    logic [7:0] v;
    v = 8'd0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_cur  = -1;
    m_last = 7;
    m_ovf  = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic [7:0] e, input logic rdy, input logic co);
    bit hs;
    bit set;
    int served;
    int pick;
    int j;
    hs     = (m_cur >= 0) && rdy;
    served = hs ? m_cur : -1;
    if (hs) begin
      exp_q.push_back(3'(m_cur));
      m_last = served;
    end
    set = 1'b0;
    for (int i = 0; i < 8; i++) if (r[i] && m_pend[i] && i != served) set = 1'b1;
    pick = -1;
`ifdef PENDING_ENCODER_ROUND_ROBIN_EN
    for (int k = 1; k <= 8; k++) begin
      j = (m_last + k) % 8;
      if (pick < 0 && m_pend[j] && e[j] && j != served) pick = j;
    end
`else
    for (int i = 0; i < 8; i++) begin
      j = i;
      if (pick < 0 && m_pend[j] && e[j] && j != served) pick = j;
    end
`endif
    if (m_cur < 0 || hs) m_cur = pick;
    if (served >= 0) m_pend[served] = 1'b0;
    for (int i = 0; i < 8; i++) if (r[i]) m_pend[i] = 1'b1;
    if (set) m_ovf = 1'b1;
    else if (co) m_ovf = 1'b0;
  endtask

  task automatic check_state();
    logic any;
    any = 1'b0;
    foreach (m_pend[i]) any |= m_pend[i];
    chk("out_valid", 32'(out_valid), 32'(m_cur >= 0));
    chk("dbg_state", 32'(dbg_state), 32'(m_cur >= 0));
    if (m_cur >= 0) chk("out_idx", 32'(out_idx), 32'(m_cur));
    chk("out_onehot", 32'(out_onehot), (m_cur >= 0) ? 32'(decode(3'(m_cur))) : 32'd0);
    chk("any_pending", 32'(any_pending), 32'(any));
    chk("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  // Called one time unit after a rising edge: check, drive, predict, advance.
  task automatic tick(input logic [7:0] r, input logic [7:0] e, input logic rdy, input logic co);
    check_state();
    req       = r;
    enable    = e;
    out_ready = rdy;
    clr_ovf   = co;
    model_step(r, e, rdy, co);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    req   = 8'hFF;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 8'h00;
    model_reset();
  endtask

  // Monitor: every accepted transfer must match the oldest predicted index.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("xfer_unexpected", 32'(out_idx), 32'hFFFF_FFFF);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        chk("xfer_idx", 32'(out_idx), 32'(e));
        chk("xfer_decode", 32'(out_onehot), 32'(decode(e)));
      end
    end
  end

  initial begin
    rst_n = 1'b0; req = 8'h00; enable = 8'hFF; out_ready = 1'b1; clr_ovf = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset(2);
    repeat (2) tick(8'h00, 8'hFF, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      tick(8'(1 << i), 8'hFF, 1'b1, 1'b0);
      repeat (3) tick(8'h00, 8'hFF, 1'b1, 1'b0);
    end

    tick(8'b1010_0110, 8'hFF, 1'b1, 1'b0);
    repeat (6) tick(8'h00, 8'hFF, 1'b1, 1'b0);

    tick(8'h09, 8'hFF, 1'b0, 1'b0);
    repeat (5) tick(8'h00, 8'hFF, 1'b0, 1'b0);
    repeat (2) tick(8'h00, 8'hFE, 1'b0, 1'b0);
    repeat (4) tick(8'h00, 8'hFE, 1'b1, 1'b0);

    tick(8'h10, 8'hFF, 1'b0, 1'b0);
    tick(8'h00, 8'hFF, 1'b0, 1'b0);
    tick(8'h10, 8'hFF, 1'b1, 1'b0);
    tick(8'h00, 8'hFF, 1'b0, 1'b0);
    tick(8'h10, 8'hFF, 1'b0, 1'b0);
    tick(8'h00, 8'hFF, 1'b0, 1'b1);
    repeat (3) tick(8'h00, 8'hFF, 1'b1, 1'b0);

    tick(8'hFF, 8'h00, 1'b1, 1'b0);
    repeat (2) tick(8'h00, 8'h00, 1'b1, 1'b1);
    repeat (10) tick(8'h00, 8'hFF, 1'b1, 1'b0);

    do_reset(1);
    repeat (12) tick(8'h21, 8'hFF, 1'b1, 1'b0);
    repeat (4) tick(8'h00, 8'hFF, 1'b1, 1'b0);

    for (int n = 0; n < 400; n++) begin
      logic [7:0] r;
      logic [7:0] e;
      r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      e = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF;
      if (n == 200) begin
        out_ready = 1'b1;
        do_reset(1);
      end
      tick(r, e, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
    end
    repeat (12) tick(8'h00, 8'hFF, 1'b1, 1'b1);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
